// File: rtl/neuron_layer3_pkg.sv
// -----------------------------------------------------------------------------
// neuron_layer3_pkg
// Shared types and helpers for the layer-3 neuron timestep sequencer.
//   state_t    : sequencer FSM states
//   idx_width  : neuron index width for a given neuron count
//   sat_signed : clamp a wide signed value into a w-bit two's-complement range
// -----------------------------------------------------------------------------
package neuron_layer3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Result is returned at 64 bits; callers truncate to w bits, which is
    // lossless because the value has already been clamped into range.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                      input int                 w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (val > max_v) begin
            return max_v;
        end else if (val < min_v) begin
            return min_v;
        end
        return val;
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// -----------------------------------------------------------------------------
// lif_update_unit
// Combinational leaky-integrate-and-fire datapath for one neuron update.
//   i_membrane     : current membrane potential (signed)
//   i_big_membrane : current big (non-leaky) membrane (signed)
//   i_current      : input current for this timestep (signed)
//   o_v_new        : leaked + integrated membrane, saturated to membrane width
//   o_b_new        : integrated big membrane, saturated to big-membrane width
//   o_spike        : o_v_new >= THRESHOLD
// -----------------------------------------------------------------------------
module lif_update_unit
    import neuron_layer3_pkg::*;
#(
    parameter int BIT_WIDTH_MEMBRANE     = 16,
    parameter int BIT_WIDTH_BIG_MEMBRANE = 16,
    parameter int BIT_WIDTH_CURRENT      = 16,
    parameter int LEAK_SHIFT             = 4,
    parameter int THRESHOLD              = 1024
) (
    input  logic signed [BIT_WIDTH_MEMBRANE-1:0]     i_membrane,
    input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] i_big_membrane,
    input  logic signed [BIT_WIDTH_CURRENT-1:0]      i_current,
    output logic signed [BIT_WIDTH_MEMBRANE-1:0]     o_v_new,
    output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] o_b_new,
    output logic                                     o_spike
);

    // Two guard bits: |leak| <= |v| and |current| fits the membrane width,
    // so v - leak + current cannot overflow MW bits.
    localparam int MW = BIT_WIDTH_MEMBRANE + 2;
    localparam int BW = BIT_WIDTH_BIG_MEMBRANE + 2;
    localparam logic signed [63:0] THR64 = 64'(THRESHOLD);

    logic signed [MW-1:0] w_mem_ext;
    logic signed [MW-1:0] w_leak;
    logic signed [MW-1:0] w_cur_m;
    logic signed [MW-1:0] w_v_sum;
    logic signed [BW-1:0] w_big_ext;
    logic signed [BW-1:0] w_cur_b;
    logic signed [BW-1:0] w_b_sum;
    logic signed [63:0]   w_v_sat;

    assign w_mem_ext = MW'(i_membrane);
    assign w_cur_m   = MW'(i_current);
    assign w_big_ext = BW'(i_big_membrane);
    assign w_cur_b   = BW'(i_current);

    // A shift of zero means "no leak", not "leak everything".
    if (LEAK_SHIFT == 0) begin : g_no_leak
        assign w_leak = '0;
    end else begin : g_leak
        assign w_leak = w_mem_ext >>> LEAK_SHIFT;
    end

    assign w_v_sum = w_mem_ext - w_leak + w_cur_m;
    assign w_b_sum = w_big_ext + w_cur_b;

    assign w_v_sat = sat_signed(64'(w_v_sum), BIT_WIDTH_MEMBRANE);
    assign o_v_new = BIT_WIDTH_MEMBRANE'(w_v_sat);
    assign o_b_new = BIT_WIDTH_BIG_MEMBRANE'(sat_signed(64'(w_b_sum), BIT_WIDTH_BIG_MEMBRANE));
    assign o_spike = (w_v_sat >= THR64);

endmodule

// File: rtl/neuron_layer3_ctrl.sv
// -----------------------------------------------------------------------------
// neuron_layer3_ctrl
// Timestep sequencer for the layer-3 neuron array. On start it walks neurons
// 0..N-1, pulls one input current per neuron over a valid/ready handshake,
// runs leak/integrate/saturate/threshold and issues the per-neuron update and
// post-spike strobes.
//   clk, reset_n                 : clock, async active-low reset
//   start_i                      : timestep start (accepted only when idle)
//   busy_o, done_o               : sweep in progress / 1-cycle completion pulse
//   current_req_o/valid_i, current_i : current fetch handshake
//   neuron_sel_o                 : neuron under service (external read mux)
//   membrane_i, big_membrane_i   : selected neuron's state via that mux
//   membrane_update_o/_valid_o   : new membrane + one-hot write strobe
//   big_membrane_update_o/_valid_o : new big membrane + one-hot write strobe
//   post_spiking_now_o           : one-hot spike/reset strobe
//   spike_vec_o                  : spikes of the last completed timestep
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start_i
// ST_FETCH  | current_req_o high, waiting for current_valid_i
// ST_UPDATE | update/spike strobes for neuron idx are on the outputs
// ST_DONE   | done_o pulse, spike_vec_o just loaded
// -----------------------------------------------------------------------------
module neuron_layer3_ctrl
    import neuron_layer3_pkg::*;
#(
    parameter int  NUM_NEURON             = 10,
    parameter int  BIT_WIDTH_MEMBRANE     = 16,
    parameter int  BIT_WIDTH_BIG_MEMBRANE = 16,
    parameter int  BIT_WIDTH_CURRENT      = 16,
    parameter int  LEAK_SHIFT             = 4,
    parameter int  THRESHOLD              = 1024,
    localparam int IDX_W                  = idx_width(NUM_NEURON)
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     start_i,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic                                     current_req_o,
    input  logic                                     current_valid_i,
    input  logic signed [BIT_WIDTH_CURRENT-1:0]      current_i,
    output logic [IDX_W-1:0]                         neuron_sel_o,
    input  logic signed [BIT_WIDTH_MEMBRANE-1:0]     membrane_i,
    input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] big_membrane_i,
    output logic signed [BIT_WIDTH_MEMBRANE-1:0]     membrane_update_o,
    output logic [NUM_NEURON-1:0]                    membrane_update_valid_o,
    output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] big_membrane_update_o,
    output logic [NUM_NEURON-1:0]                    big_membrane_update_valid_o,
    output logic [NUM_NEURON-1:0]                    post_spiking_now_o,
    output logic [NUM_NEURON-1:0]                    spike_vec_o
);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_NEURON - 1);
    localparam logic [NUM_NEURON-1:0] ONE_LSB  = NUM_NEURON'(1);

    state_t                              r_state;
    logic [IDX_W-1:0]                    r_idx;
    logic                                r_busy;
    logic                                r_done;
    logic                                r_req;
    logic signed [BIT_WIDTH_MEMBRANE-1:0]     r_mem_upd;
    logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] r_big_upd;
    logic [NUM_NEURON-1:0]               r_mem_vld;
    logic [NUM_NEURON-1:0]               r_big_vld;
    logic [NUM_NEURON-1:0]               r_post;
    logic [NUM_NEURON-1:0]               r_spike_acc;
    logic [NUM_NEURON-1:0]               r_spike_vec;

    logic signed [BIT_WIDTH_MEMBRANE-1:0]     w_v_new;
    logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] w_b_new;
    logic                                     w_spike;
    logic [NUM_NEURON-1:0]                    w_onehot;
    logic                                     w_xfer;

    assign w_onehot = ONE_LSB << r_idx;
    assign w_xfer   = current_valid_i && r_req;

    // The datapath is evaluated in the handshake cycle and its result is
    // registered on the way into ST_UPDATE. neuron_sel_o is the same in both
    // cycles and nothing writes the neuron in between, so membrane_i is
    // identical; the registered current and results then sit on registered
    // outputs for exactly the ST_UPDATE cycle.
    lif_update_unit #(
        .BIT_WIDTH_MEMBRANE     (BIT_WIDTH_MEMBRANE),
        .BIT_WIDTH_BIG_MEMBRANE (BIT_WIDTH_BIG_MEMBRANE),
        .BIT_WIDTH_CURRENT      (BIT_WIDTH_CURRENT),
        .LEAK_SHIFT             (LEAK_SHIFT),
        .THRESHOLD              (THRESHOLD)
    ) u_lif (
        .i_membrane     (membrane_i),
        .i_big_membrane (big_membrane_i),
        .i_current      (current_i),
        .o_v_new        (w_v_new),
        .o_b_new        (w_b_new),
        .o_spike        (w_spike)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req       <= 1'b0;
            r_mem_upd   <= '0;
            r_big_upd   <= '0;
            r_mem_vld   <= '0;
            r_big_vld   <= '0;
            r_post      <= '0;
            r_spike_acc <= '0;
            r_spike_vec <= '0;
        end else begin
            // Strobes and done are single-cycle unless re-asserted below.
            r_mem_vld <= '0;
            r_big_vld <= '0;
            r_post    <= '0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state     <= ST_FETCH;
                        r_idx       <= '0;
                        r_spike_acc <= '0;
                        r_busy      <= 1'b1;
                        r_req       <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (w_xfer) begin
                        r_state   <= ST_UPDATE;
                        r_req     <= 1'b0;
                        r_mem_upd <= w_v_new;
                        r_big_upd <= w_b_new;
                        r_mem_vld <= w_onehot;
                        r_big_vld <= w_onehot;
                        if (w_spike) begin
                            r_post      <= w_onehot;
                            r_spike_acc <= r_spike_acc | w_onehot;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (r_idx == LAST_IDX) begin
                        r_state     <= ST_DONE;
                        r_idx       <= '0;
                        r_done      <= 1'b1;
                        r_spike_vec <= r_spike_acc;
                    end else begin
                        r_state <= ST_FETCH;
                        r_idx   <= r_idx + 1'b1;
                        r_req   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o                      = r_busy;
    assign done_o                      = r_done;
    assign current_req_o               = r_req;
    assign neuron_sel_o                = r_idx;
    assign membrane_update_o           = r_mem_upd;
    assign membrane_update_valid_o     = r_mem_vld;
    assign big_membrane_update_o       = r_big_upd;
    assign big_membrane_update_valid_o = r_big_vld;
    assign post_spiking_now_o          = r_post;
    assign spike_vec_o                 = r_spike_vec;

endmodule

// File: tb/tb_neuron_layer3_ctrl.sv
module tb_neuron_layer3_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic valid = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-neuron stimulus tables; the external read mux is modelled by indexing
    // them with each DUT's neuron_sel_o.
    logic signed [15:0] mem_tab [4];
    logic signed [15:0] big_tab [4];
    logic signed [15:0] cur_tab [4];

    // dut_a: LEAK_SHIFT=4, dut_b: LEAK_SHIFT=0 (leak disabled)
    logic [1:0]         sel_a, sel_b;
    logic               busy_a, busy_b, done_a, done_b, req_a, req_b;
    logic signed [15:0] mem_in_a, mem_in_b, big_in_a, big_in_b, cur_a, cur_b;
    logic signed [15:0] mem_upd_a, mem_upd_b, big_upd_a, big_upd_b;
    logic [3:0]         mem_vld_a, mem_vld_b, big_vld_a, big_vld_b;
    logic [3:0]         post_a, post_b, vec_a, vec_b;

    assign mem_in_a = mem_tab[sel_a];
    assign big_in_a = big_tab[sel_a];
    assign cur_a    = cur_tab[sel_a];
    assign mem_in_b = mem_tab[sel_b];
    assign big_in_b = big_tab[sel_b];
    assign cur_b    = cur_tab[sel_b];

    neuron_layer3_ctrl #(.NUM_NEURON(4), .BIT_WIDTH_MEMBRANE(16), .BIT_WIDTH_BIG_MEMBRANE(16),
                         .BIT_WIDTH_CURRENT(16), .LEAK_SHIFT(4), .THRESHOLD(1024)) dut_a (
        .clk(clk), .reset_n(rst_n), .start_i(start_i), .busy_o(busy_a), .done_o(done_a),
        .current_req_o(req_a), .current_valid_i(valid), .current_i(cur_a),
        .neuron_sel_o(sel_a), .membrane_i(mem_in_a), .big_membrane_i(big_in_a),
        .membrane_update_o(mem_upd_a), .membrane_update_valid_o(mem_vld_a),
        .big_membrane_update_o(big_upd_a), .big_membrane_update_valid_o(big_vld_a),
        .post_spiking_now_o(post_a), .spike_vec_o(vec_a));

    neuron_layer3_ctrl #(.NUM_NEURON(4), .BIT_WIDTH_MEMBRANE(16), .BIT_WIDTH_BIG_MEMBRANE(16),
                         .BIT_WIDTH_CURRENT(16), .LEAK_SHIFT(0), .THRESHOLD(1024)) dut_b (
        .clk(clk), .reset_n(rst_n), .start_i(start_i), .busy_o(busy_b), .done_o(done_b),
        .current_req_o(req_b), .current_valid_i(valid), .current_i(cur_b),
        .neuron_sel_o(sel_b), .membrane_i(mem_in_b), .big_membrane_i(big_in_b),
        .membrane_update_o(mem_upd_b), .membrane_update_valid_o(mem_vld_b),
        .big_membrane_update_o(big_upd_b), .big_membrane_update_valid_o(big_vld_b),
        .post_spiking_now_o(post_b), .spike_vec_o(vec_b));

    // Observations from the most recent sweep
    int done_cnt, done_cyc, busy_cnt, upd_cnt, post_cnt, strobe_err, stall_err;
    logic [3:0] post_or_a, post_or_b, vec_done_a, vec_done_b;
    logic signed [15:0] got_mem_a [4];
    logic signed [15:0] got_mem_b [4];
    logic signed [15:0] got_big_a [4];
    logic signed [15:0] got_big_b [4];

    // Starts a sweep and watches it (sampling on negedges) until 25 cycles after
    // the first done_o, or a 60-cycle cap. Optionally stalls current_valid_i at
    // one neuron and pokes start_i while busy.
    task automatic run_sweep(input int stall_idx, input int stall_len, input bit poke_start);
        int  cyc;
        int  stall_cnt;
        bit  stalled;
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; upd_cnt = 0; post_cnt = 0;
        strobe_err = 0; stall_err = 0;
        post_or_a = '0; post_or_b = '0; vec_done_a = 'x; vec_done_b = 'x;
        for (int i = 0; i < 4; i++) begin
            got_mem_a[i] = 'x; got_mem_b[i] = 'x; got_big_a[i] = 'x; got_big_b[i] = 'x;
        end
        @(negedge clk);
        start_i = 1'b1;
        valid   = 1'b1;
        cyc = 0; stall_cnt = 0; stalled = 1'b0;
        while (cyc < 60 && (done_cnt == 0 || cyc < done_cyc + 25)) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (stalled && !(req_a && int'(sel_a) == stall_idx && mem_vld_a == 4'd0))
                stall_err++;
            if ((mem_vld_a | big_vld_a | post_a | mem_vld_b | big_vld_b | post_b) != 4'd0) begin
                if (mem_vld_a !== (4'b0001 << sel_a) || big_vld_a !== mem_vld_a ||
                    mem_vld_b !== mem_vld_a || big_vld_b !== mem_vld_a ||
                    (post_a & ~mem_vld_a) != 4'd0 || (post_b & ~mem_vld_b) != 4'd0 ||
                    int'(sel_a) != upd_cnt)
                    strobe_err++;
                got_mem_a[sel_a] = mem_upd_a;
                got_mem_b[sel_b] = mem_upd_b;
                got_big_a[sel_a] = big_upd_a;
                got_big_b[sel_b] = big_upd_b;
                upd_cnt++;
            end
            post_or_a |= post_a;
            post_or_b |= post_b;
            if (post_a != 4'd0) post_cnt++;
            if (busy_a) busy_cnt++;
            if (done_a !== done_b || busy_a !== busy_b) strobe_err++;
            if (done_a) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc   = cyc;
                    vec_done_a = vec_a;
                    vec_done_b = vec_b;
                end
            end
            stalled = 1'b0;
            if (req_a && int'(sel_a) == stall_idx && stall_cnt < stall_len) begin
                valid = 1'b0;
                stall_cnt++;
                stalled = 1'b1;
            end else begin
                valid = 1'b1;
            end
            if (poke_start && (cyc == 3 || cyc == done_cyc)) start_i = 1'b1;
        end
        start_i = 1'b0;
        valid   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset busy_o: got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset done_o: got %b want 0", done_a); end
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL reset current_req_o: got %b want 0", req_a); end
        checks++; if (sel_a !== 2'd0) begin errors++; $display("FAIL reset neuron_sel_o: got %0d want 0", sel_a); end
        checks++; if ((mem_vld_a | big_vld_a | post_a) !== 4'd0) begin errors++; $display("FAIL reset strobes: got %b/%b/%b want 0", mem_vld_a, big_vld_a, post_a); end
        checks++; if (vec_a !== 4'd0 || vec_b !== 4'd0) begin errors++; $display("FAIL reset spike_vec_o: got %b/%b want 0000", vec_a, vec_b); end
        checks++; if (mem_upd_a !== 16'sd0 || big_upd_a !== 16'sd0) begin errors++; $display("FAIL reset update buses: got %0d/%0d want 0", mem_upd_a, big_upd_a); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b0 || req_a !== 1'b0) begin errors++; $display("FAIL reset idle_after_release: busy=%b req=%b want 0/0", busy_a, req_a); end
    endtask

    task automatic test_basic_sweep();
        logic signed [15:0] exp_v [4] = '{16'sd100, 16'sd2000, -16'sd50, 16'sd1024};
        mem_tab = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        big_tab = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        cur_tab = '{16'sd100, 16'sd2000, -16'sd50, 16'sd1024};
        run_sweep(-1, 0, 1'b0);
        checks++; if (done_cyc !== 9) begin errors++; $display("FAIL basic done_latency: got %0d want 9", done_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic done_count: got %0d want 1", done_cnt); end
        checks++; if (busy_cnt !== 9) begin errors++; $display("FAIL basic busy_cycles: got %0d want 9", busy_cnt); end
        checks++; if (upd_cnt !== 4 || strobe_err !== 0) begin errors++; $display("FAIL basic strobes: updates=%0d bad=%0d want 4/0", upd_cnt, strobe_err); end
        checks++; if (vec_done_a !== 4'b1010 || vec_done_b !== 4'b1010) begin errors++; $display("FAIL basic spike_vec: got %b/%b want 1010", vec_done_a, vec_done_b); end
        checks++; if (post_or_a !== 4'b1010 || post_or_b !== 4'b1010 || post_cnt !== 2) begin errors++; $display("FAIL basic post_spiking: got %b/%b pulses=%0d want 1010 x2", post_or_a, post_or_b, post_cnt); end
        checks++; if (vec_a !== 4'b1010) begin errors++; $display("FAIL basic spike_vec_hold: got %b want 1010", vec_a); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_mem_a[i] !== exp_v[i] || got_mem_b[i] !== exp_v[i] || got_big_a[i] !== exp_v[i] || got_big_b[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL basic update[%0d]: got mem %0d/%0d big %0d/%0d want %0d", i, got_mem_a[i], got_mem_b[i], got_big_a[i], got_big_b[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] exp_ma [4] = '{16'sd30813, -16'sd30721, 16'sd958, -16'sd133};
        logic signed [15:0] exp_mb [4] = '{16'sd32767, -16'sd32768, 16'sd1020, -16'sd140};
        logic signed [15:0] exp_bg [4] = '{16'sd100, -16'sd32768, 16'sd32767, -16'sd35};
        mem_tab = '{16'sd32760, -16'sd32768, 16'sd1000, -16'sd100};
        big_tab = '{16'sd0, -16'sd32768, 16'sd32767, 16'sd5};
        cur_tab = '{16'sd100, -16'sd1, 16'sd20, -16'sd40};
        run_sweep(-1, 0, 1'b0);
        checks++; if (done_cyc !== 9 || strobe_err !== 0) begin errors++; $display("FAIL sat sweep: done_cyc=%0d bad=%0d want 9/0", done_cyc, strobe_err); end
        checks++; if (vec_done_a !== 4'b0001 || vec_done_b !== 4'b0001) begin errors++; $display("FAIL sat spike_vec: got %b/%b want 0001", vec_done_a, vec_done_b); end
        checks++; if (post_or_b !== 4'b0001 || post_cnt !== 1) begin errors++; $display("FAIL sat post_spiking: got %b pulses=%0d want 0001 x1", post_or_b, post_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_mem_a[i] !== exp_ma[i] || got_mem_b[i] !== exp_mb[i]) begin
                errors++;
                $display("FAIL sat membrane[%0d]: got %0d/%0d want %0d/%0d", i, got_mem_a[i], got_mem_b[i], exp_ma[i], exp_mb[i]);
            end
            checks++;
            if (got_big_a[i] !== exp_bg[i] || got_big_b[i] !== exp_bg[i]) begin
                errors++;
                $display("FAIL sat big_membrane[%0d]: got %0d/%0d want %0d", i, got_big_a[i], got_big_b[i], exp_bg[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic signed [15:0] exp_ma [4] = '{16'sd10, 16'sd20, 16'sd1069, 16'sd30};
        logic signed [15:0] exp_mb [4] = '{16'sd10, 16'sd20, 16'sd1100, 16'sd30};
        logic signed [15:0] exp_bg [4] = '{16'sd17, 16'sd20, 16'sd600, 16'sd30};
        mem_tab = '{16'sd0, 16'sd0, 16'sd500, 16'sd0};
        big_tab = '{16'sd7, 16'sd0, 16'sd0, 16'sd0};
        cur_tab = '{16'sd10, 16'sd20, 16'sd600, 16'sd30};
        run_sweep(2, 5, 1'b0);
        checks++; if (done_cyc !== 14) begin errors++; $display("FAIL stall done_latency: got %0d want 14", done_cyc); end
        checks++; if (busy_cnt !== 14) begin errors++; $display("FAIL stall busy_cycles: got %0d want 14", busy_cnt); end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall hold: bad cycles=%0d want 0", stall_err); end
        checks++; if (upd_cnt !== 4 || strobe_err !== 0) begin errors++; $display("FAIL stall strobes: updates=%0d bad=%0d want 4/0", upd_cnt, strobe_err); end
        checks++; if (vec_done_a !== 4'b0100 || vec_done_b !== 4'b0100) begin errors++; $display("FAIL stall spike_vec: got %b/%b want 0100", vec_done_a, vec_done_b); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_mem_a[i] !== exp_ma[i] || got_mem_b[i] !== exp_mb[i] || got_big_a[i] !== exp_bg[i]) begin
                errors++;
                $display("FAIL stall update[%0d]: got %0d/%0d big %0d want %0d/%0d big %0d", i, got_mem_a[i], got_mem_b[i], got_big_a[i], exp_ma[i], exp_mb[i], exp_bg[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        mem_tab = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        big_tab = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        cur_tab = '{16'sd1100, 16'sd1023, 16'sd1024, -16'sd2000};
        run_sweep(-1, 0, 1'b1);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_start done_count: got %0d want 1", done_cnt); end
        checks++; if (done_cyc !== 9) begin errors++; $display("FAIL busy_start done_latency: got %0d want 9", done_cyc); end
        checks++; if (busy_a !== 1'b0 || busy_cnt !== 9) begin errors++; $display("FAIL busy_start busy: now=%b cycles=%0d want 0/9", busy_a, busy_cnt); end
        checks++; if (vec_a !== 4'b0101 || post_cnt !== 2) begin errors++; $display("FAIL busy_start spikes: got %b pulses=%0d want 0101 x2", vec_a, post_cnt); end
    endtask

    task automatic test_reset_mid_sweep();
        int  n;
        bit  found;
        cur_tab = '{16'sd1100, 16'sd1100, 16'sd1100, 16'sd1100};
        @(negedge clk);
        start_i = 1'b1;
        valid   = 1'b1;
        found   = 1'b0;
        n       = 0;
        while (!found && n < 30) begin
            @(negedge clk);
            start_i = 1'b0;
            n++;
            if (req_a && sel_a == 2'd3) found = 1'b1;
        end
        valid = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL rst_mid reach_idx3: got n=%0d want FETCH idx3 within 30", n); end
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL rst_mid busy_o: got %b/%b want 0", busy_a, busy_b); end
        checks++; if ((mem_vld_a | big_vld_a | post_a | mem_vld_b | big_vld_b | post_b) !== 4'd0) begin errors++; $display("FAIL rst_mid strobes: got %b/%b/%b want 0", mem_vld_a, big_vld_a, post_a); end
        checks++; if (vec_a !== 4'd0 || vec_b !== 4'd0) begin errors++; $display("FAIL rst_mid spike_vec: got %b/%b want 0000", vec_a, vec_b); end
        checks++; if (req_a !== 1'b0 || sel_a !== 2'd0 || done_a !== 1'b0) begin errors++; $display("FAIL rst_mid req/sel/done: got %b/%0d/%b want 0/0/0", req_a, sel_a, done_a); end
        rst_n = 1'b1;
        run_sweep(-1, 0, 1'b0);
        checks++; if (done_cyc !== 9 || vec_done_a !== 4'b1111) begin errors++; $display("FAIL rst_mid recovery: done_cyc=%0d vec=%b want 9/1111", done_cyc, vec_done_a); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_tab = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        big_tab = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        cur_tab = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        test_reset();
        test_basic_sweep();
        test_saturation();
        test_stall();
        test_start_while_busy();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
